// File: rtl/controlador_de_interrupcao_pkg.sv
// Shared types and constants for the interrupt controller and its neighbours
// (program counter and next-address mux).
package controlador_de_interrupcao_pkg;

   localparam int N_IRQ_DEF   = 4;
   localparam int CAUSE_W_DEF = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACK     = 2'd1,
      SERVICE = 2'd2,
      RETURN  = 2'd3
   } estado_t;

   // Address the PC loads while inta is high.
   localparam logic [25:0] HANDLER_VEC = 26'd0;

endpackage

// File: rtl/controlador_de_interrupcao_if.sv
// Request/acknowledge bundle between the core (master) and the interrupt
// controller (slave).
interface controlador_de_interrupcao_if #(
   parameter int N_IRQ   = 4,
   parameter int CAUSE_W = 2
);

   logic [N_IRQ-1:0]   irq;
   logic               mask_we;
   logic [N_IRQ-1:0]   mask_in;
   logic               int_en_set;
   logic               int_en_clr;
   logic               reti;
   logic               busy;
   logic               inta;
   logic [CAUSE_W-1:0] cause;
   logic               in_service;
   logic               restore_pc;
   logic [N_IRQ-1:0]   pending;
   logic               gie;

   modport master (
      output irq, mask_we, mask_in, int_en_set, int_en_clr, reti, busy,
      input  inta, cause, in_service, restore_pc, pending, gie
   );

   modport slave (
      input  irq, mask_we, mask_in, int_en_set, int_en_clr, reti, busy,
      output inta, cause, in_service, restore_pc, pending, gie
   );

endinterface

// File: rtl/codificador_de_prioridade.sv
// Combinational priority encoder: the lowest set index of the eligible vector
// wins; valid_o flags that at least one bit is set.
module codificador_de_prioridade #(
   parameter int N_IRQ   = 4,
   parameter int CAUSE_W = 2
) (
   input  logic [N_IRQ-1:0]   eligible_i,
   output logic               valid_o,
   output logic [CAUSE_W-1:0] index_o
);

   always_comb begin
      valid_o = 1'b0;
      index_o = '0;
      // Scan downwards so the lowest index is the last one written.
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (eligible_i[i]) begin
            valid_o = 1'b1;
            index_o = CAUSE_W'(i);
         end
      end
   end

endmodule

// File: rtl/controlador_de_interrupcao.sv
// Edge-latched, maskable, non-nesting interrupt controller feeding the PC:
// one-cycle inta on acknowledge and one-cycle restore_pc on return.
module controlador_de_interrupcao
   import controlador_de_interrupcao_pkg::*;
#(
   parameter int N_IRQ   = N_IRQ_DEF,
   parameter int CAUSE_W = CAUSE_W_DEF
) (
   input  logic                          clk,
   input  logic                          reset,
   controlador_de_interrupcao_if.slave   bus
);

   logic [N_IRQ-1:0]   irq_q;
   logic [N_IRQ-1:0]   pending_q, pending_d;
   logic [N_IRQ-1:0]   mask_q, mask_d;
   logic               gie_q, gie_d;
   logic [CAUSE_W-1:0] cause_q, cause_d;
   estado_t            state_q, state_d;
   logic               inta_q, inta_d;
   logic               in_service_q, in_service_d;
   logic               restore_q, restore_d;

   logic [N_IRQ-1:0]   edge_w;
   logic [N_IRQ-1:0]   eligible;
   logic               win_valid;
   logic [CAUSE_W-1:0] win_idx;
   logic               ack_go;

   assign edge_w   = bus.irq & ~irq_q;
   assign eligible = pending_q & mask_q;

   codificador_de_prioridade #(
      .N_IRQ   (N_IRQ),
      .CAUSE_W (CAUSE_W)
   ) u_prio (
      .eligible_i (eligible),
      .valid_o    (win_valid),
      .index_o    (win_idx)
   );

   assign ack_go = (state_q == IDLE) && gie_q && win_valid && !bus.busy;

   always_comb begin
      pending_d    = pending_q;
      mask_d       = bus.mask_we ? bus.mask_in : mask_q;
      gie_d        = gie_q;
      cause_d      = cause_q;
      state_d      = state_q;
      inta_d       = 1'b0;
      in_service_d = in_service_q;
      restore_d    = 1'b0;

      if (bus.int_en_clr)
         gie_d = 1'b0;
      else if (bus.int_en_set)
         gie_d = 1'b1;

      case (state_q)
         IDLE: begin
            if (ack_go) begin
               state_d            = ACK;
               cause_d            = win_idx;
               pending_d[win_idx] = 1'b0;
               gie_d              = 1'b0;
               inta_d             = 1'b1;
               in_service_d       = 1'b1;
            end
         end
         ACK: state_d = SERVICE;
         SERVICE: begin
            if (bus.reti) begin
               state_d   = RETURN;
               restore_d = 1'b1;
            end
         end
         RETURN: begin
            // Return re-enables interrupts even against a same-cycle di.
            state_d      = IDLE;
            in_service_d = 1'b0;
            gie_d        = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      // A fresh edge beats the acknowledge clear on the same line.
      pending_d = pending_d | edge_w;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         irq_q        <= '0;
         pending_q    <= '0;
         mask_q       <= '0;
         gie_q        <= 1'b0;
         cause_q      <= '0;
         state_q      <= IDLE;
         inta_q       <= 1'b0;
         in_service_q <= 1'b0;
         restore_q    <= 1'b0;
      end else begin
         irq_q        <= bus.irq;
         pending_q    <= pending_d;
         mask_q       <= mask_d;
         gie_q        <= gie_d;
         cause_q      <= cause_d;
         state_q      <= state_d;
         inta_q       <= inta_d;
         in_service_q <= in_service_d;
         restore_q    <= restore_d;
      end
   end

   assign bus.inta       = inta_q;
   assign bus.cause      = cause_q;
   assign bus.in_service = in_service_q;
   assign bus.restore_pc = restore_q;
   assign bus.pending    = pending_q;
   assign bus.gie        = gie_q;

endmodule

// File: tb/tb_controlador_de_interrupcao.sv
// Cycle-by-cycle vector table for the interrupt controller, with a queue of
// expected output bundles, plus a hand-written unmask/return sequence.
module tb_controlador_de_interrupcao;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   controlador_de_interrupcao_if #(.N_IRQ(4), .CAUSE_W(2)) bus ();

   controlador_de_interrupcao #(.N_IRQ(4), .CAUSE_W(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Expected bundle: {inta, cause[1:0], in_service, restore_pc, pending[3:0], gie}
   typedef struct {
      logic       r;
      logic [3:0] irq;
      logic       mwe;
      logic [3:0] min;
      logic       s;
      logic       c;
      logic       rt;
      logic       b;
      logic [9:0] exp;
   } vec_t;

   vec_t       vecs[$];
   logic [9:0] sb[$];
   int         n_cmp = 0;
   int         n_bad = 0;

   function automatic vec_t mk(logic r, logic [3:0] irq, logic mwe, logic [3:0] min,
                               logic s, logic c, logic rt, logic b,
                               logic ia, logic [1:0] ca, logic is, logic rp,
                               logic [3:0] pe, logic g);
      vec_t v;
      v.r   = r;   v.irq = irq; v.mwe = mwe; v.min = min;
      v.s   = s;   v.c   = c;   v.rt  = rt;  v.b   = b;
      v.exp = {ia, ca, is, rp, pe, g};
      return v;
   endfunction

   function automatic logic [9:0] outs();
      return {bus.inta, bus.cause, bus.in_service, bus.restore_pc, bus.pending, bus.gie};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic apply(input vec_t v, input int idx);
      logic [9:0] e;
      reset          = v.r;
      bus.irq        = v.irq;
      bus.mask_we    = v.mwe;
      bus.mask_in    = v.min;
      bus.int_en_set = v.s;
      bus.int_en_clr = v.c;
      bus.reti       = v.rt;
      bus.busy       = v.b;
      sb.push_back(v.exp);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      if (outs() !== e) begin
         n_cmp++;
         n_bad++;
         $display("FAIL vec%0d {inta,cause,ins,rst,pend,gie}: got %b, required %b",
                  idx, outs(), e);
      end else begin
         n_cmp++;
      end
   endtask

   initial begin
      int waited;

      reset = 1'b1;
      bus.irq = '0; bus.mask_we = 1'b0; bus.mask_in = '0;
      bus.int_en_set = 1'b0; bus.int_en_clr = 1'b0; bus.reti = 1'b0; bus.busy = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs", 32'(outs()), 32'd0);

      // r irq mwe min s c rt b | inta cause ins rst pend gie
      // Basic service on irq[2], then reti outside SERVICE
      vecs.push_back(mk(0,4'h0,1,4'hF,1,0,0,0, 0,2'd0,0,0,4'h0,1));
      vecs.push_back(mk(0,4'h4,0,4'h0,0,0,0,0, 0,2'd0,0,0,4'h4,1));
      vecs.push_back(mk(0,4'h4,0,4'h0,0,0,0,0, 1,2'd2,1,0,4'h0,0));
      vecs.push_back(mk(0,4'h0,0,4'h0,0,0,0,0, 0,2'd2,1,0,4'h0,0));
      vecs.push_back(mk(0,4'h0,0,4'h0,0,0,0,0, 0,2'd2,1,0,4'h0,0));
      vecs.push_back(mk(0,4'h0,0,4'h0,0,0,1,0, 0,2'd2,1,1,4'h0,0));
      vecs.push_back(mk(0,4'h0,0,4'h0,0,0,0,0, 0,2'd2,0,0,4'h0,1));
      vecs.push_back(mk(0,4'h0,0,4'h0,0,0,1,0, 0,2'd2,0,0,4'h0,1));
      // Priority: irq[3] and irq[1] together
      vecs.push_back(mk(0,4'hA,0,4'h0,0,0,0,0, 0,2'd2,0,0,4'hA,1));
      vecs.push_back(mk(0,4'hA,0,4'h0,0,0,0,0, 1,2'd1,1,0,4'h8,0));
      vecs.push_back(mk(0,4'h0,0,4'h0,0,0,0,0, 0,2'd1,1,0,4'h8,0));
      vecs.push_back(mk(0,4'h0,0,4'h0,0,0,1,0, 0,2'd1,1,1,4'h8,0));
      vecs.push_back(mk(0,4'h0,0,4'h0,0,0,0,0, 0,2'd1,0,0,4'h8,1));
      vecs.push_back(mk(0,4'h0,0,4'h0,0,0,0,0, 1,2'd3,1,0,4'h0,0));
      vecs.push_back(mk(0,4'h0,0,4'h0,0,0,0,0, 0,2'd3,1,0,4'h0,0));
      vecs.push_back(mk(0,4'h0,0,4'h0,0,0,1,0, 0,2'd3,1,1,4'h0,0));
      vecs.push_back(mk(0,4'h0,0,4'h0,0,0,0,0, 0,2'd3,0,0,4'h0,1));
      // Mask gating
      vecs.push_back(mk(0,4'h0,1,4'h1,0,0,0,0, 0,2'd3,0,0,4'h0,1));
      vecs.push_back(mk(0,4'h4,0,4'h0,0,0,0,0, 0,2'd3,0,0,4'h4,1));
      vecs.push_back(mk(0,4'h0,0,4'h0,0,0,0,0, 0,2'd3,0,0,4'h4,1));
      vecs.push_back(mk(0,4'h0,1,4'h4,0,0,0,0, 0,2'd3,0,0,4'h4,1));
      vecs.push_back(mk(0,4'h0,0,4'h0,0,0,0,0, 1,2'd2,1,0,4'h0,0));
      vecs.push_back(mk(0,4'h0,0,4'h0,0,0,0,0, 0,2'd2,1,0,4'h0,0));
      vecs.push_back(mk(0,4'h0,0,4'h0,0,0,1,0, 0,2'd2,1,1,4'h0,0));
      vecs.push_back(mk(0,4'h0,0,4'h0,0,0,0,0, 0,2'd2,0,0,4'h0,1));
      // Global enable gating
      vecs.push_back(mk(0,4'h0,0,4'h0,0,1,0,0, 0,2'd2,0,0,4'h0,0));
      vecs.push_back(mk(0,4'h4,0,4'h0,0,0,0,0, 0,2'd2,0,0,4'h4,0));
      vecs.push_back(mk(0,4'h0,0,4'h0,0,0,0,0, 0,2'd2,0,0,4'h4,0));
      vecs.push_back(mk(0,4'h0,0,4'h0,1,0,0,0, 0,2'd2,0,0,4'h4,1));
      vecs.push_back(mk(0,4'h0,0,4'h0,0,0,0,0, 1,2'd2,1,0,4'h0,0));
      vecs.push_back(mk(0,4'h0,0,4'h0,0,0,0,0, 0,2'd2,1,0,4'h0,0));
      vecs.push_back(mk(0,4'h0,0,4'h0,0,0,1,0, 0,2'd2,1,1,4'h0,0));
      vecs.push_back(mk(0,4'h0,0,4'h0,0,0,0,0, 0,2'd2,0,0,4'h0,1));
      vecs.push_back(mk(0,4'h0,1,4'hF,0,0,0,0, 0,2'd2,0,0,4'h0,1));
      // busy gating, no nesting, ei during SERVICE, di during RETURN
      vecs.push_back(mk(0,4'h2,0,4'h0,0,0,0,1, 0,2'd2,0,0,4'h2,1));
      vecs.push_back(mk(0,4'h0,0,4'h0,0,0,0,1, 0,2'd2,0,0,4'h2,1));
      vecs.push_back(mk(0,4'h0,0,4'h0,0,0,0,1, 0,2'd2,0,0,4'h2,1));
      vecs.push_back(mk(0,4'h0,0,4'h0,0,0,0,0, 1,2'd1,1,0,4'h0,0));
      vecs.push_back(mk(0,4'h1,0,4'h0,0,0,0,0, 0,2'd1,1,0,4'h1,0));
      vecs.push_back(mk(0,4'h0,0,4'h0,0,0,0,0, 0,2'd1,1,0,4'h1,0));
      vecs.push_back(mk(0,4'h0,0,4'h0,1,0,0,0, 0,2'd1,1,0,4'h1,1));
      vecs.push_back(mk(0,4'h0,0,4'h0,0,0,0,0, 0,2'd1,1,0,4'h1,1));
      vecs.push_back(mk(0,4'h0,0,4'h0,0,0,1,0, 0,2'd1,1,1,4'h1,1));
      vecs.push_back(mk(0,4'h0,0,4'h0,0,1,0,0, 0,2'd1,0,0,4'h1,1));
      vecs.push_back(mk(0,4'h0,0,4'h0,0,0,0,0, 1,2'd0,1,0,4'h0,0));
      vecs.push_back(mk(0,4'h0,0,4'h0,0,0,0,0, 0,2'd0,1,0,4'h0,0));
      vecs.push_back(mk(0,4'h0,0,4'h0,0,0,1,0, 0,2'd0,1,1,4'h0,0));
      vecs.push_back(mk(0,4'h0,0,4'h0,0,0,0,0, 0,2'd0,0,0,4'h0,1));
      // irq[0] held high for ten cycles: one acknowledge only
      vecs.push_back(mk(0,4'h1,0,4'h0,0,0,0,0, 0,2'd0,0,0,4'h1,1));
      vecs.push_back(mk(0,4'h1,0,4'h0,0,0,0,0, 1,2'd0,1,0,4'h0,0));
      vecs.push_back(mk(0,4'h1,0,4'h0,0,0,0,0, 0,2'd0,1,0,4'h0,0));
      vecs.push_back(mk(0,4'h1,0,4'h0,0,0,1,0, 0,2'd0,1,1,4'h0,0));
      for (int k = 0; k < 6; k++)
         vecs.push_back(mk(0,4'h1,0,4'h0,0,0,0,0, 0,2'd0,0,0,4'h0,1));
      vecs.push_back(mk(0,4'h0,0,4'h0,0,0,0,0, 0,2'd0,0,0,4'h0,1));
      // New irq[0] edge in the ACK-entry cycle keeps it pending
      vecs.push_back(mk(0,4'h0,0,4'h0,0,1,0,0, 0,2'd0,0,0,4'h0,0));
      vecs.push_back(mk(0,4'h1,0,4'h0,0,0,0,0, 0,2'd0,0,0,4'h1,0));
      vecs.push_back(mk(0,4'h0,0,4'h0,1,0,0,0, 0,2'd0,0,0,4'h1,1));
      vecs.push_back(mk(0,4'h1,0,4'h0,0,0,0,0, 1,2'd0,1,0,4'h1,0));
      vecs.push_back(mk(0,4'h0,0,4'h0,0,0,0,0, 0,2'd0,1,0,4'h1,0));
      vecs.push_back(mk(0,4'h0,0,4'h0,0,0,1,0, 0,2'd0,1,1,4'h1,0));
      vecs.push_back(mk(0,4'h0,0,4'h0,0,0,0,0, 0,2'd0,0,0,4'h1,1));
      vecs.push_back(mk(0,4'h0,0,4'h0,0,0,0,0, 1,2'd0,1,0,4'h0,0));
      vecs.push_back(mk(0,4'h0,0,4'h0,0,0,0,0, 0,2'd0,1,0,4'h0,0));
      vecs.push_back(mk(0,4'h0,0,4'h0,0,0,1,0, 0,2'd0,1,1,4'h0,0));
      vecs.push_back(mk(0,4'h0,0,4'h0,0,0,0,0, 0,2'd0,0,0,4'h0,1));
      // ei+di together -> disabled; reti while IDLE ignored
      vecs.push_back(mk(0,4'h0,0,4'h0,1,1,0,0, 0,2'd0,0,0,4'h0,0));
      vecs.push_back(mk(0,4'h0,0,4'h0,0,0,1,0, 0,2'd0,0,0,4'h0,0));
      vecs.push_back(mk(0,4'h0,0,4'h0,1,0,0,0, 0,2'd0,0,0,4'h0,1));
      // Reset during SERVICE
      vecs.push_back(mk(0,4'h4,0,4'h0,0,0,0,0, 0,2'd0,0,0,4'h4,1));
      vecs.push_back(mk(0,4'h0,0,4'h0,0,0,0,0, 1,2'd2,1,0,4'h0,0));
      vecs.push_back(mk(0,4'h8,0,4'h0,0,0,0,0, 0,2'd2,1,0,4'h8,0));
      vecs.push_back(mk(1,4'h0,0,4'h0,0,0,1,0, 0,2'd0,0,0,4'h0,0));
      vecs.push_back(mk(0,4'h0,0,4'h0,0,0,0,0, 0,2'd0,0,0,4'h0,0));
      vecs.push_back(mk(0,4'h0,0,4'h0,1,0,0,0, 0,2'd0,0,0,4'h0,1));
      vecs.push_back(mk(0,4'h1,0,4'h0,0,0,0,0, 0,2'd0,0,0,4'h1,1));
      vecs.push_back(mk(0,4'h0,0,4'h0,0,0,0,0, 0,2'd0,0,0,4'h1,1));

      for (int i = 0; i < vecs.size(); i++)
         apply(vecs[i], i);

      // Unmasking a pending line: acknowledge one cycle after the mask write
      bus.mask_we = 1'b1;
      bus.mask_in = 4'hF;
      @(posedge clk);
      #1;
      bus.mask_we = 1'b0;
      check("unmask_no_inta_same_edge", 32'(bus.inta), 32'd0);
      waited = 0;
      while (!bus.inta && waited < 4) begin
         @(posedge clk);
         #1;
         waited++;
      end
      check("unmask_inta_latency", 32'(waited), 32'd1);
      check("unmask_cause", 32'(bus.cause), 32'd0);
      @(posedge clk);
      #1;
      check("inta_single_cycle", 32'(bus.inta), 32'd0);
      check("in_service_after_ack", 32'(bus.in_service), 32'd1);
      bus.reti = 1'b1;
      @(posedge clk);
      #1;
      bus.reti = 1'b0;
      check("restore_pulse", 32'(bus.restore_pc), 32'd1);
      @(posedge clk);
      #1;
      check("restore_single_cycle", 32'(bus.restore_pc), 32'd0);
      check("gie_after_return", 32'(bus.gie), 32'd1);
      check("idle_after_return", 32'(bus.in_service), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
